// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_responder_pkg;

    // Responder phases: waiting for a request, counting wait states, presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mr_state_t;

    // Wait-state counter width; covers WAIT_STATES up to 15.
    localparam int unsigned MR_CNT_W = 4;

    // Default geometry and latency.
    localparam int unsigned MR_DEFAULT_DEPTH       = 256;
    localparam int unsigned MR_DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request/response bundle between the CPU datapath and the memory responder.
interface mem_responder_if #(
    parameter int unsigned n = 32
) ();
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [n-1:0] req_addr;
    logic [n-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [n-1:0] rsp_rdata;
    logic         rsp_err;

    // Requester side (CPU or testbench).
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (memory).
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Synchronous single-port word RAM; a read and a write to the same word on one
// edge return the old contents. Contents are never reset.
module mem_array #(
    parameter int unsigned n     = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] index,
    input  logic [n-1:0]             wdata,
    output logic [n-1:0]             rdata
);

    logic [n-1:0] mem_r [DEPTH];

    // Registered read of the addressed word plus optional write of the same word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
        rdata <= mem_r[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one load/store at a time, inserts WAIT_STATES
// extra cycles, then holds a response (data or ack, with error flag) until taken.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned n           = 32,
    parameter int unsigned DEPTH       = MR_DEFAULT_DEPTH,
    parameter int unsigned WAIT_STATES = MR_DEFAULT_WAIT_STATES
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    // First byte address past the array, at full address width.
    localparam logic [n-1:0] ADDR_LIMIT = n'(DEPTH) << 2;

    // Counter load value on accept; the WAIT phase lasts WAIT_STATES cycles.
    localparam logic [MR_CNT_W-1:0] CNT_START =
        (WAIT_STATES == 0) ? {MR_CNT_W{1'b0}} : MR_CNT_W'(WAIT_STATES - 1);

    localparam logic [MR_CNT_W-1:0] CNT_ONE = {{(MR_CNT_W-1){1'b0}}, 1'b1};

    // Misaligned or beyond the last stored word.
    function automatic logic addr_err(input logic [n-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
    endfunction

    mr_state_t            state_r;
    mr_state_t            state_s;
    logic [MR_CNT_W-1:0]  cnt_r;
    logic [MR_CNT_W-1:0]  cnt_s;
    logic                 accept_s;
    logic                 enter_resp_s;

    logic                 we_r;
    logic [n-1:0]         addr_r;
    logic [n-1:0]         wdata_r;

    logic                 cur_we_s;
    logic [n-1:0]         cur_addr_s;
    logic [n-1:0]         cur_wdata_s;
    logic                 err_s;
    logic                 ram_we_s;
    logic [n-1:0]         ram_rdata_s;

    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic                 rsp_err_r;
    logic                 load_ok_r;

    // With zero wait states the array is accessed on the accept edge itself,
    // so the live request feeds the access path while idle.
    always_comb begin
        cur_we_s    = we_r;
        cur_addr_s  = addr_r;
        cur_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            cur_we_s    = bus.req_we;
            cur_addr_s  = bus.req_addr;
            cur_wdata_s = bus.req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    assign err_s    = addr_err(cur_addr_s);
    assign ram_we_s = enter_resp_s && cur_we_s && !err_s;

    // Next-state, counter and accept/entry strobes.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_START;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {MR_CNT_W{1'b0}}) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {MR_CNT_W{1'b0}};
            end
        endcase
    end

    // State, request latch and registered response/handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {MR_CNT_W{1'b0}};
            we_r        <= 1'b0;
            addr_r      <= {n{1'b0}};
            wdata_r     <= {n{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            load_ok_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
            if (accept_s) begin
                we_r    <= bus.req_we;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
            end
            if (enter_resp_s) begin
                rsp_err_r <= err_s;
                load_ok_r <= !cur_we_s && !err_s;
            end else if (state_s != RESP) begin
                rsp_err_r <= 1'b0;
                load_ok_r <= 1'b0;
            end
        end
    end

    mem_array #(
        .n     (n),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we_s),
        .index (cur_addr_s[AW+1:2]),
        .wdata (cur_wdata_s),
        .rdata (ram_rdata_s)
    );

    // The array output only changes on a write or index change, neither of
    // which happens while a response is held, so the masked value stays stable.
    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = load_ok_r ? ram_rdata_s : {n{1'b0}};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance,
// table vectors, hand-written corner sequences and random traffic vs. a model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.n(32)) bus2 ();
    mem_responder_if #(.n(32)) bus0 ();

    mem_responder #(.n(32), .DEPTH(256), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));
    mem_responder #(.n(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[15];

    logic [31:0] mdl2 [int unsigned];
    logic [31:0] mdl0 [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int ws, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (ws == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic set_rr(input int ws, input logic r);
        if (ws == 0) bus0.rsp_ready = r;
        else         bus2.rsp_ready = r;
    endtask

    function automatic logic g_ready(input int ws);
        return (ws == 0) ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic g_valid(input int ws);
        return (ws == 0) ? bus0.rsp_valid : bus2.rsp_valid;
    endfunction
    function automatic logic g_err(input int ws);
        return (ws == 0) ? bus0.rsp_err : bus2.rsp_err;
    endfunction
    function automatic logic [31:0] g_rdata(input int ws);
        return (ws == 0) ? bus0.rsp_rdata : bus2.rsp_rdata;
    endfunction

    // One complete transaction; returns response fields, latency in cycles
    // from the accept edge, and the cycle number of the accept edge.
    task automatic txn(input int ws, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input int stall, input bit hold_valid,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int acc_cyc);
        int guard;
        set_req(ws, 1'b1, we, a, d);
        set_rr(ws, 1'b0);
        guard = 0;
        while (!g_ready(ws) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) check("accept timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold_valid) set_req(ws, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!g_valid(ws) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd = g_rdata(ws);
        er = g_err(ws);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall rsp_valid", {31'd0, g_valid(ws)}, 32'd1);
            check("stall req_ready", {31'd0, g_ready(ws)}, 32'd0);
            check("stall rsp_rdata", g_rdata(ws), rd);
            check("stall rsp_err",   {31'd0, g_err(ws)}, {31'd0, er});
        end
        set_rr(ws, 1'b1);
        @(posedge clk); #1;
        set_rr(ws, 1'b0);
        set_req(ws, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post-handshake req_ready", {31'd0, g_ready(ws)}, 32'd1);
        check("post-handshake rsp_valid", {31'd0, g_valid(ws)}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, acc, prev_acc;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1};
        tbl[3]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
        tbl[6]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'h0000_0000, 32'h0123_4567, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0123_4567, 1'b0};
        tbl[11] = '{1'b1, 32'h1000_0010, 32'h5555_AAAA, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 32'h1000_0010, 32'h0,         32'h0, 1'b1};
        tbl[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[14] = '{1'b1, 32'h0000_0402, 32'h7777_7777, 32'h0, 1'b1};

        reset = 1'b0;
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rr(2, 1'b0);
        set_rr(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w <= 2; w += 2) begin
            check($sformatf("reset ws%0d req_ready", w), {31'd0, g_ready(w)}, 32'd1);
            check($sformatf("reset ws%0d rsp_valid", w), {31'd0, g_valid(w)}, 32'd0);
            check($sformatf("reset ws%0d rsp_rdata", w), g_rdata(w), 32'd0);
            check($sformatf("reset ws%0d rsp_err", w),   {31'd0, g_err(w)}, 32'd0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Known background at 0x10, then a store that is killed by reset in WAIT.
        txn(2, 1'b1, 32'h10, 32'h1111_1111, 0, 1'b0, rd, er, lat, acc);
        set_req(2, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        check("in WAIT req_ready", {31'd0, g_ready(2)}, 32'd0);
        check("in WAIT rsp_valid", {31'd0, g_valid(2)}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid-WAIT reset req_ready", {31'd0, g_ready(2)}, 32'd1);
        check("mid-WAIT reset rsp_valid", {31'd0, g_valid(2)}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("after reset req_ready", {31'd0, g_ready(2)}, 32'd1);
        check("after reset rsp_valid", {31'd0, g_valid(2)}, 32'd0);
        txn(2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat, acc);
        check("aborted store not performed", rd, 32'h1111_1111);
        check("aborted store load err", {31'd0, er}, 32'd0);

        // Table vectors, back to back with rsp_ready taken immediately.
        prev_acc = -1;
        for (int i = 0; i < 15; i++) begin
            txn(2, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 1'b0, rd, er, lat, acc);
            check($sformatf("tbl[%0d] rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl[%0d] err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl[%0d] latency", i), lat, 32'd3);
            if (prev_acc >= 0) check($sformatf("tbl[%0d] accept spacing", i), acc - prev_acc, 32'd4);
            prev_acc = acc;
        end

        // Backpressure: response held five cycles with req_valid kept high.
        txn(2, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er, lat, acc);
        check("backpressure rdata", rd, 32'hDEAD_BEEF);
        check("backpressure latency", lat, 32'd3);
        @(posedge clk); #1;
        check("backpressure single handshake", {31'd0, g_valid(2)}, 32'd0);
        check("backpressure still idle", {31'd0, g_ready(2)}, 32'd1);

        // Zero-wait-state instance: last word of the array.
        txn(0, 1'b1, 32'h3FC, 32'hA5A5_A5A5, 0, 1'b0, rd, er, lat, prev_acc);
        check("ws0 store rdata", rd, 32'h0);
        check("ws0 store err", {31'd0, er}, 32'd0);
        check("ws0 store latency", lat, 32'd1);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, rd, er, lat, acc);
        check("ws0 load rdata", rd, 32'hA5A5_A5A5);
        check("ws0 load err", {31'd0, er}, 32'd0);
        check("ws0 load latency", lat, 32'd1);
        check("ws0 accept spacing", acc - prev_acc, 32'd2);

        // Random traffic on both instances against a word-map model.
        for (int w = 0; w <= 2; w += 2) begin
            for (int k = 0; k < 150; k++) begin
                logic [31:0] a, d, exp_d;
                logic        we, exp_e;
                int unsigned sel, widx;
                sel = $urandom_range(0, 9);
                if (sel < 7) begin
                    widx = (sel < 4) ? $urandom_range(0, 7) : $urandom_range(248, 255);
                    a = widx * 4;
                end else if (sel == 7) begin
                    a = $urandom_range(0, 1023) | 32'd1;
                end else begin
                    a = $urandom;
                end
                we = $urandom_range(0, 1);
                d  = $urandom;
                exp_e = (a % 4 != 0) || (longint'(a) >= 4 * 256);
                exp_d = 32'h0;
                txn(w, we, a, d, $urandom_range(0, 3), 1'b0, rd, er, lat, acc);
                check($sformatf("rnd ws%0d #%0d err", w, k), {31'd0, er}, {31'd0, exp_e});
                check($sformatf("rnd ws%0d #%0d latency", w, k), lat, w + 1);
                if (!exp_e && we) begin
                    if (w == 0) mdl0[a / 4] = d;
                    else        mdl2[a / 4] = d;
                    check($sformatf("rnd ws%0d #%0d store rdata", w, k), rd, 32'h0);
                end else if (exp_e) begin
                    check($sformatf("rnd ws%0d #%0d err rdata", w, k), rd, 32'h0);
                end else if (w == 0 && mdl0.exists(a / 4)) begin
                    exp_d = mdl0[a / 4];
                    check($sformatf("rnd ws0 #%0d load rdata", k), rd, exp_d);
                end else if (w == 2 && mdl2.exists(a / 4)) begin
                    exp_d = mdl2[a / 4];
                    check($sformatf("rnd ws2 #%0d load rdata", k), rd, exp_d);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data-memory responder for the 32-bit MIPS CPU: the memory-side end of the load/store interface the datapath drives with `aluout` (address), `writedata` and `readdata`. It accepts one request at a time over a valid/ready handshake and models a fixed number of wait states. It returns read data or a write acknowledgement with an error flag for misaligned or out-of-range addresses. It lets the core be tested against a non-zero-latency memory before a real cache or bus exists.

## Interface
- `n`, 32, data and address width in bits
- `DEPTH`, 256, number of 32-bit words stored; power of two, at least 2
- `WAIT_STATES`, 2, extra cycles between request accept and response; 0 to 15
- `clk`  input  1  single clock; all state changes on its rising edge
- `reset`  input  1  asynchronous, active-low reset
- `req_valid`  input  1  request present
- `req_ready`  output  1  responder can accept a request
- `req_we`  input  1  1 = store word, 0 = load word
- `req_addr`  input  n  byte address
- `req_wdata`  input  n  store data
- `rsp_valid`  output  1  response present
- `rsp_ready`  input  1  requester can take the response
- `rsp_rdata`  output  n  load data; 0 for stores and errors
- `rsp_err`  output  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch we, addr and wdata.
  - Go to WAIT with counter=`WAIT_STATES`-1, or straight to RESP if `WAIT_STATES`=0.
- **WAIT**
  - `req_ready`=0.
  - Counter decrements each cycle.
  - When counter=0, the next edge enters RESP.
- **Entering RESP** (a single edge does all of the following):
  - Compute err = (addr[1:0]≠0) || (addr ≥ 4·`DEPTH`), compared at full n-bit width.
  - Word index = addr[$clog2(DEPTH)+1:2].
  - Store without err: write wdata to the word; `rsp_rdata`=0.
  - Load without err: `rsp_rdata` = stored word (pre-write value; only one access is in flight).
  - Any err: no write; `rsp_rdata`=0, `rsp_err`=1.
- **RESP**
  - `rsp_valid`=1, `req_ready`=0.
  - Outputs hold stable until `rsp_valid`&&`rsp_ready`.
  - On that handshake, the next state is IDLE.
  - No combinational path from `rsp_ready` to `req_ready`.
- Storage contents are not cleared by reset and are uninitialised until written.
- Inputs are ignored outside IDLE, and `req_*` is ignored when `req_valid`=0.

## Timing
- Reset (asynchronous assert, any state):
  - Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
  - A request in flight is dropped; a pending store in WAIT is not performed.
  - Release takes effect at the first rising edge with `reset`=1.
- Latency from the accept edge to the first cycle with `rsp_valid`=1 is `WAIT_STATES`+1 cycles.
- With `rsp_ready` held high, back-to-back throughput is one request per `WAIT_STATES`+2 cycles.
- `rsp_ready`=0 in RESP stalls indefinitely with outputs held. `req_valid` during the stall is not accepted.
- `req_ready` and `rsp_valid` are registered state decodes and are never both 1.

## Structure
- Package `mem_responder_pkg`:
  - state enum `mr_state_t` {IDLE, WAIT, RESP}
  - 4-bit wait-counter width constant
  - default `DEPTH` and `WAIT_STATES` localparams
- Sub-module `mem_array`:
  - `DEPTH`×n synchronous single-port word RAM
  - ports: clk, we, index, wdata, rdata
  - read-before-write on the same edge
- FSM, counter, error check and response registers live in `mem_responder`.

## Test plan
- Reset mid-WAIT: accept store 0xDEADBEEF at 0x10, assert `reset` low in WAIT, release, then load 0x10 → no store performed; after reset `req_ready`=1 and `rsp_valid`=0.
- Store then load, `WAIT_STATES`=2, `rsp_ready`=1: store 0xDEADBEEF to 0x10, then load 0x10.
  - `rsp_valid` rises exactly 3 cycles after each accept.
  - Store response: `rsp_rdata`=0, `rsp_err`=0.
  - Load response: `rsp_rdata`=0xDEADBEEF.
  - The second accept occurs 4 cycles after the first.
- Backpressure: load 0x10 with `rsp_ready`=0 for 5 cycles while `req_valid`=1 → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout; one handshake, then IDLE.
- Errors: store 0x12345678 to 0x13 (misaligned) and to 0x400 (`DEPTH`=256) → `rsp_err`=1, `rsp_rdata`=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
- `WAIT_STATES`=0 build: load 0x3FC after storing 0xA5A5A5A5 there → `rsp_valid` 1 cycle after accept with 0xA5A5A5A5; last word addressable, no error.
